// File: rtl/ir_rx_pkg.sv
// ir_rx_pkg: shared types and helpers for the IR frame receiver.
//   state_e     : receiver FSM state (IDLE, MARK, SPACE)
//   mark_cls_e  : classification of a completed mark
//   LEN_W       : width of the saturating mark/space tick counters
//   classify()  : maps a mark length onto its class from the length windows
//   sat_inc()   : saturating increment for the LEN_W counters
package ir_rx_pkg;

    localparam int LEN_W = 8;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CLS_START = 2'd0,
        CLS_ONE   = 2'd1,
        CLS_ZERO  = 2'd2,
        CLS_BAD   = 2'd3
    } mark_cls_e;

    function automatic mark_cls_e classify(
        input logic [LEN_W-1:0] len,
        input int start_min, input int start_max,
        input int one_min,   input int one_max,
        input int zero_min,  input int zero_max
    );
        int l;
        l = int'(len);
        if (l >= start_min && l <= start_max)     return CLS_START;
        else if (l >= one_min && l <= one_max)    return CLS_ONE;
        else if (l >= zero_min && l <= zero_max)  return CLS_ZERO;
        else                                      return CLS_BAD;
    endfunction

    // Holds at LEN_MAX so an overlong mark or space never wraps back into a window.
    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (v == LEN_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ir_frame_rx_if.sv
// ir_frame_rx_if: bundle between the IR line, the receiver and its consumer.
//   serial      : raw IR line (async to clk)
//   frame_data  : last accepted payload, first received bit in MSB
//   frame_valid : frame_data holds an unconsumed frame
//   frame_ready : consumer takes the frame when high together with frame_valid
//   busy        : a frame is in progress
//   error       : one-cycle pulse on a framing/parity error
//   overrun     : one-cycle pulse when a completed frame is dropped
//   dbg_state   : receiver FSM state, for observation only
// Handshake: a frame transfers on every clk edge where frame_valid and
// frame_ready are both high; frame_valid stays high and frame_data stays stable
// until that happens, and frame_ready may be driven independently of frame_valid.
interface ir_frame_rx_if #(
    parameter int DATA_WIDTH = 23
);
    import ir_rx_pkg::*;

    logic                  serial;
    logic [DATA_WIDTH-1:0] frame_data;
    logic                  frame_valid;
    logic                  frame_ready;
    logic                  busy;
    logic                  error;
    logic                  overrun;
    state_e                dbg_state;

    modport master (
        input  serial, frame_ready,
        output frame_data, frame_valid, busy, error, overrun, dbg_state
    );

    modport slave (
        output serial, frame_ready,
        input  frame_data, frame_valid, busy, error, overrun, dbg_state
    );

endinterface

// File: rtl/ir_tick_gen.sv
// ir_tick_gen: divides clk by TICK_DIV and emits a one-clk sample tick.
//   clk, reset : clock and synchronous active-high reset
//   o_tick     : registered one-cycle pulse, once every TICK_DIV clocks
module ir_tick_gen #(
    parameter int TICK_DIV = 1950
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == CNT_W'(TICK_DIV - 1)) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/ir_frame_rx.sv
// ir_frame_rx: pulse-width IR frame receiver.
// Samples the synchronised IR line once per tick, measures each mark and
// classifies it as START / ONE / ZERO from the length windows, assembles
// frames MSB-first and hands them out through a valid/ready output register.
//   clk, reset : clock and synchronous active-high reset
//   bus        : ir_frame_rx_if.master (serial in, frame handshake out,
//                busy / error / overrun status, dbg_state)
// Build option: IR_RX_PARITY_EN adds a trailing even-parity bit per frame;
// a mismatch pulses error and drops the frame.
module ir_frame_rx
    import ir_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 23,
    parameter int TICK_DIV   = 1950,
    parameter int START_MIN  = 30,
    parameter int START_MAX  = 32,
    parameter int ONE_MIN    = 14,
    parameter int ONE_MAX    = 18,
    parameter int ZERO_MIN   = 6,
    parameter int ZERO_MAX   = 10,
    parameter int GAP_MAX    = 16
) (
    input logic           clk,
    input logic           reset,
    ir_frame_rx_if.master bus
);

`ifdef IR_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_BITS = DATA_WIDTH + PAR_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    logic [1:0]            r_sync;
    state_e                r_state;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_gap;
    logic [FRAME_BITS-1:0] r_sr;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_error;
    logic                  r_overrun;

    logic                  w_tick;
    logic                  w_line;
    mark_cls_e             w_cls;
    logic [FRAME_BITS-1:0] w_sr_next;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  w_done;
    logic [DATA_WIDTH-1:0] w_payload;
    logic                  w_par_ok;
    logic [LEN_W-1:0]      w_gap_next;

    ir_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .o_tick (w_tick)
    );

    assign w_line     = r_sync[1];
    assign w_cls      = classify(r_len, START_MIN, START_MAX, ONE_MIN, ONE_MAX,
                                 ZERO_MIN, ZERO_MAX);
    assign w_sr_next  = {r_sr[FRAME_BITS-2:0], (w_cls == CLS_ONE)};
    assign w_cnt_next = r_bit_cnt + 1'b1;
    assign w_done     = (w_cnt_next == CNT_W'(FRAME_BITS));
    // Payload sits above the optional parity bit, so it is always the top bits.
    assign w_payload  = w_sr_next[FRAME_BITS-1 -: DATA_WIDTH];
    assign w_gap_next = sat_inc(r_gap);
`ifdef IR_RX_PARITY_EN
    assign w_par_ok   = ((^w_payload) == w_sr_next[0]);
`else
    assign w_par_ok   = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync    <= '0;
            r_state   <= IDLE;
            r_len     <= '0;
            r_gap     <= '0;
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_error   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], bus.serial};
            r_error   <= 1'b0;
            r_overrun <= 1'b0;
            if (r_valid && bus.frame_ready)
                r_valid <= 1'b0;

            if (w_tick) begin
                case (r_state)
                    IDLE: begin
                        if (w_line) begin
                            r_state <= MARK;
                            r_len   <= LEN_W'(1);
                        end
                    end
                    MARK: begin
                        if (w_line) begin
                            r_len <= sat_inc(r_len);
                        end else begin
                            // The first low sample already counts as one space tick.
                            r_state <= SPACE;
                            r_gap   <= LEN_W'(1);
                            case (w_cls)
                                CLS_START: begin
                                    // Also taken mid-frame: restart without error.
                                    r_sr      <= '0;
                                    r_bit_cnt <= '0;
                                    r_busy    <= 1'b1;
                                end
                                CLS_ONE, CLS_ZERO: begin
                                    if (r_busy) begin
                                        r_sr      <= w_sr_next;
                                        r_bit_cnt <= w_cnt_next;
                                        if (w_done) begin
                                            r_busy    <= 1'b0;
                                            r_bit_cnt <= '0;
                                            if (!w_par_ok) begin
                                                r_error <= 1'b1;
                                            end else if (!r_valid || bus.frame_ready) begin
                                                r_data  <= w_payload;
                                                r_valid <= 1'b1;
                                            end else begin
                                                r_overrun <= 1'b1;
                                            end
                                        end
                                    end
                                end
                                default: begin
                                    if (r_busy) begin
                                        r_error <= 1'b1;
                                        r_busy  <= 1'b0;
                                    end
                                end
                            endcase
                        end
                    end
                    SPACE: begin
                        if (w_line) begin
                            r_state <= MARK;
                            r_len   <= LEN_W'(1);
                            r_gap   <= '0;
                        end else begin
                            r_gap <= w_gap_next;
                            if (int'(w_gap_next) >= GAP_MAX) begin
                                r_state <= IDLE;
                                r_gap   <= '0;
                                if (r_busy) begin
                                    r_error <= 1'b1;
                                    r_busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.frame_data  = r_data;
    assign bus.frame_valid = r_valid;
    assign bus.busy        = r_busy;
    assign bus.error       = r_error;
    assign bus.overrun     = r_overrun;
    assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_ir_frame_rx.sv
// tb_ir_frame_rx: directed bench for ir_frame_rx with TICK_DIV=4, 23-bit
// frames and 8-tick spaces. Marks are held for exactly N*TICK_DIV clocks,
// so each mark is seen as exactly N high samples.
module tb_ir_frame_rx;
    import ir_rx_pkg::*;

    localparam int DW       = 23;
    localparam int TDIV     = 4;
    localparam int T_START  = 31;
    localparam int T_ONE    = 16;
    localparam int T_ZERO   = 8;
    localparam int T_SPACE  = 8;
    localparam int T_IDLE   = 20;
    localparam int T_BAD    = 24;

    logic clk = 1'b0;
    logic reset = 1'b1;

    ir_frame_rx_if #(.DATA_WIDTH(DW)) bus ();

    ir_frame_rx #(.DATA_WIDTH(DW), .TICK_DIV(TDIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Event monitor: cumulative counts, read as before/after differences.
    int            n_err   = 0;
    int            n_ovr   = 0;
    int            n_vrise = 0;
    int            n_vhigh = 0;
    logic [DW-1:0] last_data = '0;
    logic          prev_valid = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.error === 1'b1)   n_err++;
            if (bus.overrun === 1'b1) n_ovr++;
            if (bus.frame_valid === 1'b1) n_vhigh++;
            if (bus.frame_valid === 1'b1 && prev_valid !== 1'b1) begin
                n_vrise++;
                last_data = bus.frame_data;
            end
        end
        prev_valid = bus.frame_valid;
    end

    task automatic send_mark(input int n);
        bus.serial = 1'b1;
        repeat (n * TDIV) @(negedge clk);
        bus.serial = 1'b0;
    endtask

    task automatic send_space(input int n);
        bus.serial = 1'b0;
        repeat (n * TDIV) @(negedge clk);
    endtask

    task automatic send_start();
        send_mark(T_START);
        send_space(T_SPACE);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_mark(v[i] ? T_ONE : T_ZERO);
            send_space(T_SPACE);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] v);
        send_start();
        send_bits({9'd0, v}, DW);
`ifdef IR_RX_PARITY_EN
        send_bits({31'd0, ^v}, 1);
`endif
    endtask

    task automatic test_reset();
        bus.serial      = 1'b0;
        bus.frame_ready = 1'b0;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (bus.frame_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.frame_data); end
        total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.frame_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", bus.error); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
        total++; if (bus.dbg_state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want IDLE", bus.dbg_state); end
    endtask

    task automatic test_single();
        int e0 = n_err;
        int v0 = n_vrise;
        int h0 = n_vhigh;
        bus.frame_ready = 1'b1;
        send_frame(23'h5A5A5A);
        send_space(T_IDLE);
        total++; if (n_vrise - v0 !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", n_vrise - v0); end
        total++; if (last_data !== 23'h5A5A5A) begin bad++; $display("FAIL single_data: got %h want 5a5a5a", last_data); end
        total++; if (n_vhigh - h0 !== 1) begin bad++; $display("FAIL single_valid_len: got %0d want 1", n_vhigh - h0); end
        total++; if (n_err - e0 !== 0) begin bad++; $display("FAIL single_error: got %0d want 0", n_err - e0); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_overrun();
        int v0 = n_vrise;
        int o0 = n_ovr;
        bus.frame_ready = 1'b0;
        send_frame(23'h123456);
        send_space(T_IDLE);
        send_frame(23'h654321);
        send_space(T_IDLE);
        total++; if (n_vrise - v0 !== 1) begin bad++; $display("FAIL ovr_loads: got %0d want 1", n_vrise - v0); end
        total++; if (n_ovr - o0 !== 1) begin bad++; $display("FAIL ovr_pulse: got %0d want 1", n_ovr - o0); end
        total++; if (bus.frame_data !== 23'h123456) begin bad++; $display("FAIL ovr_data: got %h want 123456", bus.frame_data); end
        total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid_held: got %b want 1", bus.frame_valid); end
        bus.frame_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL ovr_valid_clear: got %b want 0", bus.frame_valid); end
        total++; if (bus.frame_data !== 23'h123456) begin bad++; $display("FAIL ovr_data_kept: got %h want 123456", bus.frame_data); end
    endtask

    task automatic test_bad_mark();
        int e0 = n_err;
        int v0 = n_vrise;
        bus.frame_ready = 1'b1;
        send_start();
        send_bits(32'hABC, 12);
        send_mark(T_BAD);
        send_space(T_SPACE);
        total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL bad_error: got %0d want 1", n_err - e0); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL bad_busy: got %b want 0", bus.busy); end
        total++; if (n_vrise - v0 !== 0) begin bad++; $display("FAIL bad_no_frame: got %0d want 0", n_vrise - v0); end
        send_space(T_IDLE);
        send_frame(23'h2AAAAA);
        send_space(T_IDLE);
        total++; if (n_vrise - v0 !== 1) begin bad++; $display("FAIL bad_next_count: got %0d want 1", n_vrise - v0); end
        total++; if (last_data !== 23'h2AAAAA) begin bad++; $display("FAIL bad_next_data: got %h want 2aaaaa", last_data); end
    endtask

    task automatic test_gap_timeout();
        int e0 = n_err;
        int v0 = n_vrise;
        send_start();
        send_bits(32'h5C3, 12);
        send_space(T_IDLE);
        total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL gap_error: got %0d want 1", n_err - e0); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL gap_busy: got %b want 0", bus.busy); end
        total++; if (bus.dbg_state !== IDLE) begin bad++; $display("FAIL gap_state: got %0d want IDLE", bus.dbg_state); end
        total++; if (n_vrise - v0 !== 0) begin bad++; $display("FAIL gap_no_frame: got %0d want 0", n_vrise - v0); end
    endtask

    task automatic test_resync();
        int e0 = n_err;
        int v0 = n_vrise;
        send_start();
        send_bits(32'h3FF, 10);
        send_frame(23'h3C3C3C);
        send_space(T_IDLE);
        total++; if (n_vrise - v0 !== 1) begin bad++; $display("FAIL resync_count: got %0d want 1", n_vrise - v0); end
        total++; if (last_data !== 23'h3C3C3C) begin bad++; $display("FAIL resync_data: got %h want 3c3c3c", last_data); end
        total++; if (n_err - e0 !== 0) begin bad++; $display("FAIL resync_error: got %0d want 0", n_err - e0); end
    endtask

`ifdef IR_RX_PARITY_EN
    task automatic test_parity();
        int e0 = n_err;
        int v0 = n_vrise;
        bus.frame_ready = 1'b1;
        send_start();
        send_bits(32'h1, DW);
        send_bits(32'h0, 1);
        send_space(T_IDLE);
        total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL par_bad_error: got %0d want 1", n_err - e0); end
        total++; if (n_vrise - v0 !== 0) begin bad++; $display("FAIL par_bad_frame: got %0d want 0", n_vrise - v0); end
        send_start();
        send_bits(32'h1, DW);
        send_bits(32'h1, 1);
        send_space(T_IDLE);
        total++; if (n_vrise - v0 !== 1) begin bad++; $display("FAIL par_ok_frame: got %0d want 1", n_vrise - v0); end
        total++; if (last_data !== 23'h000001) begin bad++; $display("FAIL par_ok_data: got %h want 000001", last_data); end
    endtask
`endif

    initial begin
        bus.serial      = 1'b0;
        bus.frame_ready = 1'b0;
        test_reset();
        test_single();
        test_overrun();
        test_bad_mark();
        test_gap_timeout();
        test_resync();
`ifdef IR_RX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
